// File: rtl/hash_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hash_tx_pkg : shared types and constants for the hash serial transmitter |
// | Optional parity bit controlled by macro HASH_TX_PARITY_EN.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package hash_tx_pkg;

   localparam int EVENT_W = 10;

   localparam logic [1:0] TAG_Z1   = 2'b01;
   localparam logic [1:0] TAG_Z2   = 2'b10;
   localparam logic [1:0] TAG_BOTH = 2'b11;

`ifdef HASH_TX_PARITY_EN
   localparam int FRAME_BITS = 13;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      TAG    = 3'd2,
      HASH   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } tx_state_t;
`else
   localparam int FRAME_BITS = 12;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      TAG   = 3'd2,
      HASH  = 3'd3,
      STOP  = 3'd5
   } tx_state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/hash_event_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hash_event_fifo : synchronous first-word-fall-through event queue.       |
// | A push into a full queue is accepted only if a pop occurs on that edge.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hash_event_fifo
   import hash_tx_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic [EVENT_W-1:0] data_in,
   output logic               full,
   output logic               empty,
   output logic [EVENT_W-1:0] data
);

   localparam int AW = $clog2(DEPTH);

   logic [EVENT_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        count;
   logic               do_push;
   logic               do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign data    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/hash_serial_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hash_serial_tx : queues match events and sends them as framed serial    |
// | data (start, tag, hash, [parity if HASH_TX_PARITY_EN], stop).            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hash_serial_tx
   import hash_tx_pkg::*;
#(
   parameter int BAUD_DIV = 4,
   parameter int DEPTH    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] hash_in,
   input  logic       match1,
   input  logic       match2,
   output logic       tx_line,
   output logic       busy,
   output logic [7:0] frame_count,
   output logic       overflow
);

   localparam logic [7:0] BAUD_LAST = 8'(BAUD_DIV - 1);

   tx_state_t          state;
   tx_state_t          state_next;
   logic               push;
   logic               pop;
   logic               load;
   logic               full;
   logic               empty;
   logic [EVENT_W-1:0] fifo_data;
   logic [7:0]         baud_cnt;
   logic [2:0]         bit_idx;
   logic [9:0]         shreg;
   logic               bit_end;
   logic               frame_done;
`ifdef HASH_TX_PARITY_EN
   logic               parity;
`endif

   assign push       = match1 | match2;
   assign bit_end    = (baud_cnt == BAUD_LAST);
   assign frame_done = (state == STOP) && bit_end;
   assign busy       = (state != IDLE);

   hash_event_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .data_in ({match2, match1, hash_in}),
      .full    (full),
      .empty   (empty),
      .data    (fifo_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      load       = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               load       = 1'b1;
               state_next = START;
            end
         end
         START: if (bit_end) state_next = TAG;
         TAG:   if (bit_end && bit_idx == 3'd1) state_next = HASH;
         HASH: begin
            if (bit_end && bit_idx == 3'd7) begin
`ifdef HASH_TX_PARITY_EN
               state_next = PARITY;
`else
               state_next = STOP;
`endif
            end
         end
`ifdef HASH_TX_PARITY_EN
         PARITY: if (bit_end) state_next = STOP;
`endif
         STOP: begin
            if (bit_end) begin
               // Chain straight into the next queued frame without an idle bit.
               if (!empty) begin
                  pop        = 1'b1;
                  load       = 1'b1;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      tx_line = 1'b1;
      case (state)
         START:      tx_line = 1'b0;
         TAG, HASH:  tx_line = shreg[0];
`ifdef HASH_TX_PARITY_EN
         PARITY:     tx_line = parity;
`endif
         default:    tx_line = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         baud_cnt    <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         frame_count <= '0;
         overflow    <= 1'b0;
`ifdef HASH_TX_PARITY_EN
         parity      <= 1'b0;
`endif
      end else begin
         if (load) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            // Tag occupies the low bits so it shifts out ahead of the hash.
            shreg    <= {fifo_data[7:0], fifo_data[9:8]};
`ifdef HASH_TX_PARITY_EN
            parity   <= ^fifo_data;
`endif
         end else if (state != IDLE) begin
            if (bit_end) begin
               baud_cnt <= '0;
               bit_idx  <= (state_next == state) ? bit_idx + 3'd1 : 3'd0;
               if (state == TAG || state == HASH) begin
                  shreg <= {1'b0, shreg[9:1]};
               end
            end else begin
               baud_cnt <= baud_cnt + 8'd1;
            end
         end
         if (frame_done) begin
            frame_count <= frame_count + 8'd1;
         end
         if (push && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hash_serial_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hash_serial_tx : scoreboard bench; stimulus queues expected frames,  |
// | a line monitor decodes frames and compares them. Revision: 1.0          |
// +--------------------------------------------------------------------------+
module tb_hash_serial_tx;
   import hash_tx_pkg::*;

   localparam int B = 4;
   localparam int D = 4;
`ifdef HASH_TX_PARITY_EN
   localparam int FB = 13;
`else
   localparam int FB = 12;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       match1 = 1'b0;
   logic       match2 = 1'b0;
   logic [7:0] hash_in = 8'h00;
   logic       tx_line;
   logic       busy;
   logic [7:0] frame_count;
   logic       overflow;

   int checks = 0;
   int errors = 0;
   logic [12:0] exp_q [$];

   hash_serial_tx #(
      .BAUD_DIV (B),
      .DEPTH    (D)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .hash_in     (hash_in),
      .match1      (match1),
      .match2      (match2),
      .tx_line     (tx_line),
      .busy        (busy),
      .frame_count (frame_count),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   // Wire-order frame: bit 0 is the start bit.
   function automatic logic [12:0] mk(input logic [1:0] tag, input logic [7:0] h);
      logic [12:0] f;
      f    = '0;
      f[1] = tag[0];
      f[2] = tag[1];
      for (int i = 0; i < 8; i++) f[3+i] = h[i];
`ifdef HASH_TX_PARITY_EN
      f[11] = ^{tag, h};
      f[12] = 1'b1;
`else
      f[11] = 1'b1;
`endif
      return f;
   endfunction

   // Line monitor
   int          mon_n = 0;
   logic        mon_act = 1'b0;
   logic [12:0] mon_f = '0;
   logic        mon_glitch = 1'b0;
   logic [12:0] mon_exp;

   always @(negedge clk) begin
      if (rst) begin
         mon_act = 1'b0;
      end else begin
         if (!mon_act && tx_line == 1'b0) begin
            mon_act    = 1'b1;
            mon_n      = 0;
            mon_f      = '0;
            mon_glitch = 1'b0;
         end
         if (mon_act) begin
            if (mon_n % B == 0) mon_f[mon_n / B] = tx_line;
            else if (tx_line !== mon_f[mon_n / B]) mon_glitch = 1'b1;
            mon_n++;
            if (mon_n == FB * B) begin
               mon_act = 1'b0;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL frame: got unexpected frame %b, expected none", mon_f);
               end else begin
                  mon_exp = exp_q.pop_front();
                  if (mon_f !== mon_exp || mon_glitch) begin
                     errors++;
                     $display("FAIL frame: got %b (unstable=%0d) expected %b", mon_f, mon_glitch, mon_exp);
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      repeat (n) @(negedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic send1(input logic [1:0] tag, input logic [7:0] h);
      @(negedge clk);
      match1  = tag[0];
      match2  = tag[1];
      hash_in = h;
      @(negedge clk);
      match1  = 1'b0;
      match2  = 1'b0;
      hash_in = 8'hFF;
   endtask

   task automatic measure_busy(input string name, input int exp_len);
      int t;
      int len;
      t   = 0;
      len = 0;
      while (!busy && t < 50) begin
         @(negedge clk);
         t++;
      end
      while (busy && len < 5000) begin
         len++;
         @(negedge clk);
      end
      chk(name, len, exp_len);
   endtask

   task automatic line_quiet(input string name, input int cycles);
      int lows;
      lows = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (tx_line !== 1'b1 || busy !== 1'b0) lows++;
      end
      chk(name, lows, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset and idle line
      repeat (8) @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_tx_line", tx_line, 1);
      chk("reset_busy", busy, 0);
      chk("reset_frame_count", frame_count, 0);
      chk("reset_overflow", overflow, 0);
      line_quiet("idle_line", 20);

      // Single event, hand-computed frame
`ifdef HASH_TX_PARITY_EN
      exp_q.push_back(13'b1_1101_0010_1010);
      send1(TAG_Z1, 8'hA5);
`else
      exp_q.push_back(13'b0_1101_0010_1100);
      send1(TAG_Z2, 8'hA5);
`endif
      chk("pre_start_line", tx_line, 1);
      @(negedge clk);
      chk("start_latency", tx_line, 0);
      measure_busy("busy_len_single", FB * B);
      chk("frame_count_single", frame_count, 1);

      // Both strobes together
      do_reset(2);
      exp_q.push_back(mk(TAG_BOTH, 8'h3C));
      send1(TAG_BOTH, 8'h3C);
      measure_busy("busy_len_both", FB * B);
      chk("frame_count_both", frame_count, 1);

      // Six back-to-back events into a 4-deep queue
      do_reset(2);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         match1  = 1'b1;
         hash_in = 8'h10 + 8'(i * 17);
         if (i < 5) exp_q.push_back(mk(TAG_Z1, 8'h10 + 8'(i * 17)));
      end
      @(negedge clk);
      match1  = 1'b0;
      hash_in = 8'h00;
      // Four busy samples have already passed by this point.
      measure_busy("busy_len_burst", 5 * FB * B - 4);
      chk("overflow_burst", overflow, 1);
      chk("frame_count_burst", frame_count, 5);

      // Reset during the fourth hash bit with two events still queued
      do_reset(2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         match1  = 1'b1;
         hash_in = 8'h55 + 8'(i * 17);
      end
      @(negedge clk);
      match1 = 1'b0;
      repeat (24) @(negedge clk);
      chk("pre_reset_busy", busy, 1);
      #1 rst = 1'b1;
      @(negedge clk);
      #1 rst = 1'b0;
      chk("midreset_tx_line", tx_line, 1);
      chk("midreset_busy", busy, 0);
      chk("midreset_frame_count", frame_count, 0);
      line_quiet("after_midreset", 200);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
